// File: rtl/pid_pkg.sv
// pid_pkg: shared types, limits and set-point slew helper
// for the PID loop sequencer.
package pid_pkg;

  localparam int SAMPLE_W = 8;
  localparam int CTRL_W = 10;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [SAMPLE_W:0] diff_t;
  typedef logic signed [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_MAX = ctrl_t'(511);
  localparam ctrl_t CTRL_MIN = ctrl_t'(-512);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef logic [1:0] fcode_t;
  localparam fcode_t FC_NONE = 2'd0;
  localparam fcode_t FC_SAT = 2'd1;
  localparam fcode_t FC_STALE = 2'd2;

  // One slew step toward tgt; 9-bit difference so no wrap.
  function automatic sample_t slew(
    input sample_t sp,
    input sample_t tgt,
    input int step
  );
    diff_t diff;
    diff_t st;
    st = diff_t'(step);
    diff = diff_t'(tgt) - diff_t'(sp);
    if (diff > st) return sp + sample_t'(step);
    else if (diff < -st) return sp - sample_t'(step);
    else return tgt;
  endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: SAMPLE_DIV divider producing the PID core
// clock-enable strobe, with synchronous clear and enable.
module pid_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: PID core sequencing, soft start and fault guard.
// Soft-start ramp is built only with PID_SEQ_SOFTSTART_EN defined.
module pid_loop_sequencer
  import pid_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100,
  parameter int unsigned RAMP_STEP = 1,
  parameter int unsigned PID_LAT = 3,
  parameter int unsigned SAT_LIMIT = 16,
  parameter int unsigned STALE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  sample_t     target,
  input  sample_t     meas,
  input  logic        meas_valid,
  input  ctrl_t       pid_out,
  output logic        pid_rst,
  output logic        pid_tick,
  output sample_t     pid_in,
  output sample_t     pid_sp,
  output ctrl_t       ctrl_out,
  output logic        ctrl_valid,
  output logic [2:0]  state,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int SW = $clog2(SAT_LIMIT + 1);
  localparam int TW = $clog2(STALE_MAX + 1);
  localparam int LW = $clog2(PID_LAT + 1);
  localparam logic [LW-1:0] LAT_FULL = LW'(PID_LAT);

  if (SAMPLE_DIV < 2 || RAMP_STEP < 1 || RAMP_STEP > 127) begin : g_bad_cfg
    $error("pid_loop_sequencer: SAMPLE_DIV or RAMP_STEP out of range");
  end

  state_t cur, nxt;
  logic active;
  logic fresh, fresh_now;
  logic sat_now, sat_hit, stale_hit;
  logic [SW-1:0] sat_cnt;
  logic [TW-1:0] stale_cnt;
  logic [LW-1:0] lat_cnt;
  ctrl_t ctrl_q;
  sample_t sp_slew;

  assign active = (cur == S_RAMP) || (cur == S_RUN);
  assign fresh_now = fresh || meas_valid;
  assign sat_now = (pid_out == CTRL_MAX) || (pid_out == CTRL_MIN);
  assign stale_hit = pid_tick && !fresh_now
                  && (stale_cnt == TW'(STALE_MAX - 1));
  assign sat_hit = pid_tick && sat_now
                && (sat_cnt == SW'(SAT_LIMIT - 1));
  assign sp_slew = slew(pid_sp, target, int'(RAMP_STEP));
  assign state = cur;

  pid_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cur == S_START),
    .en      (active),
    .tick    (pid_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= S_IDLE;
    else cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE: if (enable) nxt = S_START;
`ifdef PID_SEQ_SOFTSTART_EN
      S_START: nxt = S_RAMP;
`else
      S_START: nxt = S_RUN;
`endif
      S_RAMP, S_RUN: begin
        if (stale_hit || sat_hit) nxt = S_FAULT;
        else if (cur == S_RAMP && pid_tick && sp_slew == target)
          nxt = S_RUN;
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
    if (!enable) nxt = S_IDLE;
  end

  always_comb begin
    pid_rst = 1'b1;
    ctrl_valid = 1'b0;
    ctrl_out = '0;
    fault = 1'b0;
    unique case (1'b1)
      active: begin
        pid_rst = 1'b0;
        ctrl_valid = (lat_cnt == LAT_FULL);
        ctrl_out = ctrl_valid ? ctrl_q : '0;
      end
      (cur == S_FAULT): fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pid_in <= '0;
      pid_sp <= '0;
      fresh <= 1'b0;
      sat_cnt <= '0;
      stale_cnt <= '0;
      lat_cnt <= '0;
      ctrl_q <= '0;
      fault_code <= FC_NONE;
    end else begin
      if (meas_valid) pid_in <= meas;
      // a tick consumes freshness even if a sample lands with it
      if (pid_tick) fresh <= 1'b0;
      else if (meas_valid) fresh <= 1'b1;
      if (cur == S_IDLE || cur == S_START) begin
        sat_cnt <= '0;
        stale_cnt <= '0;
        lat_cnt <= '0;
        ctrl_q <= '0;
      end else if (pid_tick) begin
        stale_cnt <= fresh_now ? '0 : stale_cnt + 1'b1;
        sat_cnt <= sat_now ? sat_cnt + 1'b1 : '0;
        if (lat_cnt != LAT_FULL) lat_cnt <= lat_cnt + 1'b1;
        if (lat_cnt >= LW'(PID_LAT - 1)) ctrl_q <= pid_out;
      end
`ifdef PID_SEQ_SOFTSTART_EN
      if (cur == S_START) pid_sp <= pid_in;
      else if (pid_tick) pid_sp <= sp_slew;
`else
      if (cur == S_START || cur == S_RUN) pid_sp <= target;
`endif
      if (nxt == S_IDLE) fault_code <= FC_NONE;
      else if (nxt == S_FAULT && cur != S_FAULT)
        fault_code <= stale_hit ? FC_STALE : FC_SAT;
    end
  end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb_pid_loop_sequencer: directed vector bench for the sequencer,
// covering both soft-start and direct-start builds.
module tb_pid_loop_sequencer;
  import pid_pkg::*;

  localparam int DIV = 4;
`ifdef PID_SEQ_SOFTSTART_EN
  localparam int ST_ACT = 2;
`else
  localparam int ST_ACT = 3;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic meas_valid = 1'b0;
  sample_t target = '0;
  sample_t meas = '0;
  ctrl_t pid_out = '0;

  logic pid_rst, pid_tick, ctrl_valid, fault;
  sample_t pid_in, pid_sp;
  ctrl_t ctrl_out;
  logic [2:0] state;
  logic [1:0] fault_code;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    sample_t tgt;
    ctrl_t   pout;
    int      st;
    int      sp;
    int      vld;
    int      co;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  pid_loop_sequencer #(
    .SAMPLE_DIV (DIV),
    .RAMP_STEP  (3),
    .PID_LAT    (3),
    .SAT_LIMIT  (16),
    .STALE_MAX  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .target     (target),
    .meas       (meas),
    .meas_valid (meas_valid),
    .pid_out    (pid_out),
    .pid_rst    (pid_rst),
    .pid_tick   (pid_tick),
    .pid_in     (pid_in),
    .pid_sp     (pid_sp),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .state      (state),
    .fault      (fault),
    .fault_code (fault_code)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Step negedges until a tick is seen, then past its edge.
  task automatic wait_tick(output int n, input bit with_meas);
    n = 0;
    while (!pid_tick && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (!pid_tick) begin
      nvec++;
      nerr++;
      $display("FAIL tick_timeout: got no tick, want one in %0d cycles",
               3 * DIV);
    end
    if (with_meas) meas_valid = 1'b1;
    @(negedge clk);
    if (with_meas) meas_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
`ifdef PID_SEQ_SOFTSTART_EN
    tbl[0] = '{8'sd20, 10'sd100, 2, 13, 0, 0};
    tbl[1] = '{8'sd20, 10'sd101, 2, 16, 0, 0};
    tbl[2] = '{8'sd20, 10'sd102, 2, 19, 1, 102};
    tbl[3] = '{8'sd20, -10'sd300, 3, 20, 1, -300};
    tbl[4] = '{8'sd20, 10'sd5, 3, 20, 1, 5};
    tbl[5] = '{8'sd14, 10'sd6, 3, 17, 1, 6};
    tbl[6] = '{8'sd14, 10'sd7, 3, 14, 1, 7};
    tbl[7] = '{8'sh80, 10'sd8, 3, 11, 1, 8};
`else
    tbl[0] = '{8'sd20, 10'sd100, 3, 20, 0, 0};
    tbl[1] = '{8'sd20, 10'sd101, 3, 20, 0, 0};
    tbl[2] = '{8'sd20, 10'sd102, 3, 20, 1, 102};
    tbl[3] = '{8'sd20, -10'sd300, 3, 20, 1, -300};
    tbl[4] = '{8'sd20, 10'sd5, 3, 20, 1, 5};
    tbl[5] = '{8'sd14, 10'sd6, 3, 14, 1, 6};
    tbl[6] = '{8'sd14, 10'sd7, 3, 14, 1, 7};
    tbl[7] = '{8'sh80, 10'sd8, 3, -128, 1, 8};
`endif

    meas = 8'sd10;
    meas_valid = 1'b1;
    target = 8'sd20;
    pid_out = 10'sd100;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_pid_rst", int'(pid_rst), 1);
    chk("rst_pid_sp", int'(pid_sp), 0);
    chk("rst_pid_in", int'(pid_in), 0);
    chk("rst_ctrl_valid", int'(ctrl_valid), 0);
    chk("rst_fault_code", int'(fault_code), 0);

    reset_n = 1'b1;
    @(negedge clk);
    chk("meas_latch", int'(pid_in), 10);
    enable = 1'b1;
    @(negedge clk);
    chk("start_state", int'(state), 1);
    chk("start_pid_rst", int'(pid_rst), 1);
    @(negedge clk);
    chk("post_start_state", int'(state), ST_ACT);
    chk("post_start_sp", int'(pid_sp), (ST_ACT == 2) ? 10 : 20);
    chk("post_start_pid_rst", int'(pid_rst), 0);

    for (int i = 0; i < 8; i++) begin
      target = tbl[i].tgt;
      pid_out = tbl[i].pout;
      wait_tick(n, 1'b0);
      chk($sformatf("v%0d_period", i), n, DIV - 1);
      chk($sformatf("v%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("v%0d_sp", i), int'(pid_sp), tbl[i].sp);
      chk($sformatf("v%0d_valid", i), int'(ctrl_valid), tbl[i].vld);
      chk($sformatf("v%0d_ctrl", i), int'(ctrl_out), tbl[i].co);
    end

    for (int i = 1; i <= 16; i++) begin
      pid_out = (i % 2 == 1) ? CTRL_MAX : CTRL_MIN;
      wait_tick(n, 1'b0);
      if (i < 16) chk($sformatf("sat%0d_state", i), int'(state), 3);
      if (i == 15) chk("sat15_ctrl", int'(ctrl_out), 511);
    end
    chk("sat_state", int'(state), 4);
    chk("sat_fault", int'(fault), 1);
    chk("sat_code", int'(fault_code), 1);
    chk("sat_ctrl", int'(ctrl_out), 0);
    chk("sat_valid", int'(ctrl_valid), 0);
    chk("sat_pid_rst", int'(pid_rst), 1);
    ticks = 0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (pid_tick) ticks++;
    end
    chk("fault_ticks", ticks, 0);
    chk("fault_hold", int'(state), 4);
    enable = 1'b0;
    @(negedge clk);
    chk("clr_state", int'(state), 0);
    chk("clr_fault", int'(fault), 0);
    chk("clr_code", int'(fault_code), 0);

    pid_out = '0;
    target = -8'sd50;
    meas_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("stale_start", int'(state), 1);
    @(negedge clk);
    chk("stale_act", int'(state), ST_ACT);
    chk("stale_sp", int'(pid_sp), (ST_ACT == 2) ? 10 : -50);
    for (int i = 1; i <= 5; i++) begin
      wait_tick(n, 1'b0);
      if (i == 4) chk("stale4_state", int'(state), ST_ACT);
    end
    chk("stale_state", int'(state), 4);
    chk("stale_code", int'(fault_code), 2);
    enable = 1'b0;
    @(negedge clk);
    chk("stale_idle", int'(state), 0);

    meas = 8'sd33;
    meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
    meas = 8'sd44;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      wait_tick(n, i == 5);
      if (i == 5) begin
        chk("coin_state", int'(state), ST_ACT);
        chk("coin_code", int'(fault_code), 0);
        chk("coin_pid_in", int'(pid_in), 44);
      end
      if (i == 8) chk("coin8_state", int'(state), ST_ACT);
    end
    chk("coin9_state", int'(state), 4);
    chk("coin9_code", int'(fault_code), 2);
    enable = 1'b0;
    @(negedge clk);

    meas = 8'sd10;
    meas_valid = 1'b1;
    target = 8'sd120;
    pid_out = 10'sd77;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) wait_tick(n, 1'b0);
    chk("pre_rst_valid", int'(ctrl_valid), 1);
    chk("pre_rst_ctrl", int'(ctrl_out), 77);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_pid_rst", int'(pid_rst), 1);
    chk("arst_tick", int'(pid_tick), 0);
    chk("arst_pid_in", int'(pid_in), 0);
    chk("arst_pid_sp", int'(pid_sp), 0);
    chk("arst_ctrl", int'(ctrl_out), 0);
    chk("arst_valid", int'(ctrl_valid), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_code", int'(fault_code), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Sequencing controller for the shared PID core of the power-signal path. It generates the core's sample strobe, owns the core's active-high reset, soft-starts the set point from the measured value toward the requested target, latches ADC measurements through a valid handshake, and qualifies the core's 10-bit control output before it reaches the PWM stage. It also detects persistent saturation and stale measurements and forces a safe zero-control fault state.

## Interface
- SAMPLE_DIV, 100: clk cycles per PID sample tick (≥2).
- RAMP_STEP, 1: set-point increment per tick during soft start (1..127).
- PID_LAT, 3: core pipeline depth in ticks before its output is trusted.
- SAT_LIMIT, 16: consecutive saturated ticks that raise a fault.
- STALE_MAX, 4: consecutive ticks without a fresh measurement that raise a fault.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  loop enable, level.
- target  in  8  signed requested set point.
- meas  in  8  signed plant measurement.
- meas_valid  in  1  one-cycle strobe; meas is valid this cycle.
- pid_out  in  10  signed control from core.
- pid_rst  out  1  active-high core reset.
- pid_tick  out  1  one-cycle core clock-enable strobe.
- pid_in  out  8  signed held measurement to core.
- pid_sp  out  8  signed current set point to core.
- ctrl_out  out  10  signed qualified control to PWM.
- ctrl_valid  out  1  ctrl_out is trustworthy.
- state  out  3  FSM state encoding.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 none, 1 saturation, 2 stale measurement.

## Operation
- FSM states: IDLE(0), START(1), RAMP(2), RUN(3), FAULT(4).
- IDLE: pid_rst=1, no ticks, ctrl_out=0, ctrl_valid=0. enable=1 → START.
- START: exactly one cycle; pid_rst stays 1; pid_sp loaded with current meas register; tick divider cleared; → RAMP.
- RAMP: pid_rst=0; on each pid_tick pid_sp moves toward target by RAMP_STEP, clamped to land exactly on target (difference computed 9-bit signed, no wrap). When pid_sp==target after an update → RUN.
- RUN: pid_sp follows target with the same ramp rule (target changes are slewed, never stepped).
- FAULT: pid_rst=1, ctrl_out=0, ctrl_valid=0, fault=1, fault_code held. Exit only via enable=0 → IDLE.
- enable=0 in any state → IDLE on the next edge; fault and fault_code clear on entry to IDLE.
- Measurement: meas_valid latches meas into pid_in and sets a fresh flag; each pid_tick clears fresh. A tick with fresh=0 increments stale count, else clears it; count reaching STALE_MAX in RAMP/RUN → FAULT code 2.
- Saturation: on each tick in RAMP/RUN, pid_out==511 or pid_out==-512 increments sat count, else clears it; reaching SAT_LIMIT → FAULT code 1. Stale wins if both hit on the same tick.
- Qualification: tick count since START saturates at PID_LAT; ctrl_valid=1 once it reaches PID_LAT while in RAMP/RUN. ctrl_out updated from pid_out on each tick while valid, held between ticks; 0 otherwise.

## Timing
- Reset: state=IDLE, pid_rst=1, pid_tick=0, pid_in=0, pid_sp=0, ctrl_out=0, ctrl_valid=0, fault=0, fault_code=0; counters 0.
- enable rising at edge N: START at N+1, RAMP at N+2; first pid_tick at N+1+SAMPLE_DIV.
- pid_tick period exactly SAMPLE_DIV cycles in RAMP/RUN; never asserted in IDLE, START or FAULT.
- pid_sp updates on the edge following pid_tick high; core sees the new value at the next tick.
- meas_valid coincident with pid_tick: sample is captured and counts as fresh for that tick.
- Fault detection to FAULT state: one cycle after the offending tick.
- reset_n asserted mid-operation: all outputs to reset values immediately, regardless of clk.

## Configuration
- PID_SEQ_SOFTSTART_EN defined: RAMP state and slew behaviour as above.
- Undefined: START → RUN directly; pid_sp loaded from target in START and follows target each cycle unslewed; RAMP_STEP ignored; state code 2 never appears.

## Structure
- Shared package pid_pkg: state enum, fault-code constants, CTRL_MAX=511 / CTRL_MIN=-512, data widths (8-bit sample, 10-bit control).
- One sub-module: pid_tick_gen (SAMPLE_DIV divider with synchronous clear and enable, emits pid_tick).

## Test plan
- Reset then enable=1, meas=10, target=20, RAMP_STEP=3, SAMPLE_DIV=4 → pid_sp 10,13,16,19,20 on successive ticks, then state=RUN.
- pid_out held at 511 for 16 ticks in RUN → FAULT, fault_code=1, ctrl_out=0, pid_rst=1; enable=0 → IDLE, fault cleared.
- meas_valid withheld for 4 ticks → FAULT code 2; a valid on the 4th tick instead keeps RUN.
- After START, ctrl_valid stays 0 for first 2 ticks and rises after 3rd tick; ctrl_out then equals pid_out sampled at each tick.
- reset_n pulsed low mid-RAMP between clk edges → all outputs at reset values immediately, state=IDLE.
- Build without PID_SEQ_SOFTSTART_EN: enable with target=-50 → pid_sp=-50 one cycle after START, state goes 1→3.
